reg_file_sb: RTL and testbench

Architectural integer register file for the Titan RV32I core, with a per-register scoreboard. It is the responder for the decode/writeback stages. It provides two combinational read ports and one synchronous write port, with x0 hardwired to zero and same-cycle write-to-read bypass. A pending-write bit per register lets decode stall on RAW hazards until writeback retires the producer.

---
 rtl/reg_file_sb.sv | 92 +++++++++
 tb/tb_reg_file_sb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// RV32I architectural register file with a per-register pending-write scoreboard.
// Two combinational read ports and one write port. Writes bypass to reads in the same cycle, and x0 is always zero.
module reg_file_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   read_addr_rs1,
    input  logic [AW-1:0]   read_addr_rs2,
    output logic [XLEN-1:0] data_rs1,
    output logic [XLEN-1:0] data_rs2,
    input  logic            we,
    input  logic [AW-1:0]   write_addr_rd,
    input  logic [XLEN-1:0] write_data_rd,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            busy_rs1,
    output logic            busy_rs2,
    output logic            stall
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    logic wrActive;
    logic retireRs1;
    logic retireRs2;
    logic retireIssue;

    assign wrActive    = we && (write_addr_rd != '0);
    assign retireRs1   = wrActive && (write_addr_rd == read_addr_rs1);
    assign retireRs2   = wrActive && (write_addr_rd == read_addr_rs2);
    assign retireIssue = we && (write_addr_rd == issue_rd);

    // Set after clear, so a new producer wins over a retire of the old producer in the same cycle.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wrActive) begin
            regs_d[write_addr_rd] = write_data_rd;
        end
        if (we) begin
            busy_d[write_addr_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        if (read_addr_rs1 == '0) begin
            data_rs1 = '0;
        end else if (retireRs1) begin
            data_rs1 = write_data_rd;
        end else begin
            data_rs1 = regs_q[read_addr_rs1];
        end
    end

    always_comb begin
        if (read_addr_rs2 == '0) begin
            data_rs2 = '0;
        end else if (retireRs2) begin
            data_rs2 = write_data_rd;
        end else begin
            data_rs2 = regs_q[read_addr_rs2];
        end
    end

    // A retiring producer is already on the bypass path, so it is not a hazard in this cycle.
    assign busy_rs1 = busy_q[read_addr_rs1] & ~retireRs1;
    assign busy_rs2 = busy_q[read_addr_rs2] & ~retireRs2;
    assign stall    = issue_valid & (busy_rs1 | busy_rs2 | (busy_q[issue_rd] & ~retireIssue));

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb. An array model is checked on every cycle, and literal spot checks pin the model.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  read_addr_rs1, read_addr_rs2, write_addr_rd, issue_rd;
    logic [31:0] data_rs1, data_rs2, write_data_rd;
    logic        we, issue_valid;
    logic        busy_rs1, busy_rs2, stall;

    int assertCount = 0;
    int failCount = 0;
    bit checkEn = 1'b0;

    logic [31:0] modelRegs [32];
    bit          modelBusy [32];

    reg_file_sb #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst(rst),
        .read_addr_rs1(read_addr_rs1), .read_addr_rs2(read_addr_rs2),
        .data_rs1(data_rs1), .data_rs2(data_rs2),
        .we(we), .write_addr_rd(write_addr_rd), .write_data_rd(write_data_rd),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] expData(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (we && write_addr_rd == a) return write_data_rd;
        return modelRegs[a];
    endfunction

    function automatic bit expBusy(input logic [4:0] a);
        return modelBusy[a] && !(we && write_addr_rd == a && a != 5'd0);
    endfunction

    // Architectural state advances on each rising edge from the inputs held during that cycle.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                modelRegs[i] = 32'd0;
                modelBusy[i] = 1'b0;
            end
        end else begin
            if (we && write_addr_rd != 5'd0) modelRegs[write_addr_rd] = write_data_rd;
            if (we) modelBusy[write_addr_rd] = 1'b0;
            if (issue_valid && issue_rd != 5'd0) modelBusy[issue_rd] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            bit b1, b2, st;
            b1 = expBusy(read_addr_rs1);
            b2 = expBusy(read_addr_rs2);
            st = issue_valid && (b1 || b2 || (modelBusy[issue_rd] && !(we && write_addr_rd == issue_rd)));
            checkOutput("model data_rs1", data_rs1, expData(read_addr_rs1));
            checkOutput("model data_rs2", data_rs2, expData(read_addr_rs2));
            checkOutput("model busy_rs1", {31'd0, busy_rs1}, {31'd0, b1});
            checkOutput("model busy_rs2", {31'd0, busy_rs2}, {31'd0, b2});
            checkOutput("model stall", {31'd0, stall}, {31'd0, st});
        end
    end

    task automatic applyStimulus(input logic [4:0] r1, input logic [4:0] r2, input logic w,
                                 input logic [4:0] wa, input logic [31:0] wd,
                                 input logic iv, input logic [4:0] ird);
        read_addr_rs1 = r1;
        read_addr_rs2 = r2;
        we            = w;
        write_addr_rd = wa;
        write_data_rd = wd;
        issue_valid   = iv;
        issue_rd      = ird;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic atSample();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        step();
        rst = 1'b0;
        checkEn = 1'b1;

        // Reset state
        applyStimulus(5'd0, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        atSample();
        checkOutput("reset data_rs1", data_rs1, 32'd0);
        checkOutput("reset data_rs2", data_rs2, 32'd0);
        checkOutput("reset busy", {30'd0, busy_rs1, busy_rs2}, 32'd0);
        checkOutput("reset stall", {31'd0, stall}, 32'd0);
        step();

        // Basic write, then a write to x0 that must be discarded
        applyStimulus(5'd0, 5'd0, 1'b1, 5'd1, 32'd7, 1'b0, 5'd0);
        step();
        applyStimulus(5'd0, 5'd1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        atSample();
        checkOutput("write x1", data_rs2, 32'h7);
        step();
        applyStimulus(5'd0, 5'd0, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0);
        step();
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        atSample();
        checkOutput("x0 read", data_rs1, 32'd0);
        step();

        // Same-cycle bypass
        applyStimulus(5'd0, 5'd0, 1'b1, 5'd3, 32'h11, 1'b0, 5'd0);
        step();
        applyStimulus(5'd3, 5'd3, 1'b1, 5'd3, 32'h22, 1'b0, 5'd0);
        atSample();
        checkOutput("bypass rs1", data_rs1, 32'h22);
        checkOutput("bypass rs2", data_rs2, 32'h22);
        step();
        applyStimulus(5'd3, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        atSample();
        checkOutput("after bypass", data_rs1, 32'h22);
        step();

        // RAW hazard on x4
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4);
        step();
        applyStimulus(5'd4, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        atSample();
        checkOutput("raw busy_rs1", {31'd0, busy_rs1}, 32'd1);
        checkOutput("raw stall", {31'd0, stall}, 32'd1);
        issue_valid = 1'b0;
        step();
        applyStimulus(5'd4, 5'd0, 1'b1, 5'd4, 32'h55, 1'b1, 5'd8);
        atSample();
        checkOutput("retire busy_rs1", {31'd0, busy_rs1}, 32'd0);
        checkOutput("retire stall", {31'd0, stall}, 32'd0);
        checkOutput("retire data", data_rs1, 32'h55);
        step();
        applyStimulus(5'd4, 5'd8, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        atSample();
        checkOutput("x4 cleared", {31'd0, busy_rs1}, 32'd0);
        checkOutput("x8 busy", {31'd0, busy_rs2}, 32'd1);
        step();

        // Simultaneous issue and retire on x6
        applyStimulus(5'd0, 5'd0, 1'b1, 5'd6, 32'h9, 1'b1, 5'd6);
        step();
        applyStimulus(5'd6, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        atSample();
        checkOutput("x6 busy", {31'd0, busy_rs1}, 32'd1);
        checkOutput("x6 data", data_rs1, 32'h9);
        step();

        // Reset mid-operation discards state
        applyStimulus(5'd0, 5'd0, 1'b1, 5'd2, 32'h33, 1'b1, 5'd2);
        step();
        applyStimulus(5'd2, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        atSample();
        checkOutput("x2 before rst", data_rs1, 32'h33);
        checkOutput("x2 busy before rst", {31'd0, busy_rs1}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        applyStimulus(5'd2, 5'd6, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
        atSample();
        checkOutput("x2 after rst", data_rs1, 32'd0);
        checkOutput("x2 busy after rst", {31'd0, busy_rs1}, 32'd0);
        checkOutput("x6 busy after rst", {31'd0, busy_rs2}, 32'd0);
        checkOutput("issue x0 stall", {31'd0, stall}, 32'd0);
        step();
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
        atSample();
        checkOutput("x0 never busy", {31'd0, stall}, 32'd0);
        step();

        // WAW hazard, cleared by a same-cycle retire of the old producer
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        step();
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        atSample();
        checkOutput("waw stall", {31'd0, stall}, 32'd1);
        we = 1'b1;
        write_addr_rd = 5'd9;
        write_data_rd = 32'hA5;
        #1;
        checkOutput("waw retire stall", {31'd0, stall}, 32'd0);
        step();

        // Writeback to a non-busy register, then a sweep of both ports
        for (int i = 10; i < 20; i++) begin
            applyStimulus(5'(i - 1), 5'(i), 1'b1, 5'(i), 32'h1000 + 32'(i) * 32'h111, 1'b0, 5'd0);
            step();
        end
        for (int i = 10; i < 20; i++) begin
            applyStimulus(5'(i), 5'(29 - i), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
            step();
        end
        applyStimulus(5'd15, 5'd15, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        atSample();
        checkOutput("x15 sweep", data_rs1, 32'h1000 + 32'd15 * 32'h111);
        checkOutput("x15 not busy", {31'd0, busy_rs2}, 32'd0);
        step();

        checkEn = 1'b0;
        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
